// File: rtl/issue_slot_entry.sv
// One out-of-order issue queue slot: holds a renamed micro-op, snoops writeback
// tags to wake its source operands, requests issue when ready, drops on grant/kill.
module issue_slot_entry #(
    parameter  int WIDTH_REG = 6,
    parameter  int WIDTH_TAG = 6,
    parameter  int WIDTH_BRM = 4,
    localparam int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [WIDTH-1:0]       i_data,
    input  logic [4*WIDTH_REG-1:0] i_WDest4x,
    input  logic [WIDTH_BRM-1:0]   i_BrKill,
    input  logic                   i_grant,
    input  logic                   i_en,
    output logic                   o_request,
    output logic [WIDTH-1:0]       o_rslot,
    output logic [WIDTH-1:0]       o_data
);

    localparam int BIT_RDY1  = 0;
    localparam int BIT_RDY2  = 1;
    localparam int BIT_VALID = 2;
    localparam int POS_PR1   = 3;
    localparam int POS_PR2   = 3 + WIDTH_REG;
    localparam int POS_BRM   = 3 + 3*WIDTH_REG + WIDTH_TAG;

    function automatic logic tag_hit(
        input logic [WIDTH_REG-1:0]   pr,
        input logic [4*WIDTH_REG-1:0] wdest
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hit = hit | (wdest[k*WIDTH_REG +: WIDTH_REG] == pr);
        end
        return hit;
    endfunction

    logic [WIDTH-1:0] slot_q;
    logic [WIDTH-1:0] slot_d;
    logic [WIDTH-1:0] next_entry;
    logic [WIDTH-1:0] load_entry;
    logic             kill_s;
    logic             kill_in;

    always_comb begin
        kill_s  = |(slot_q[POS_BRM +: WIDTH_BRM] & i_BrKill);
        kill_in = |(i_data[POS_BRM +: WIDTH_BRM] & i_BrKill);

        next_entry            = slot_q;
        next_entry[BIT_RDY1]  = slot_q[BIT_RDY1] | tag_hit(slot_q[POS_PR1 +: WIDTH_REG], i_WDest4x);
        next_entry[BIT_RDY2]  = slot_q[BIT_RDY2] | tag_hit(slot_q[POS_PR2 +: WIDTH_REG], i_WDest4x);
        next_entry[BIT_VALID] = slot_q[BIT_VALID] & ~kill_s & ~i_grant;

        // A freshly loaded op sees the same-cycle writebacks and kills; grant cannot apply yet.
        load_entry            = i_data;
        load_entry[BIT_RDY1]  = i_data[BIT_RDY1] | tag_hit(i_data[POS_PR1 +: WIDTH_REG], i_WDest4x);
        load_entry[BIT_RDY2]  = i_data[BIT_RDY2] | tag_hit(i_data[POS_PR2 +: WIDTH_REG], i_WDest4x);
        load_entry[BIT_VALID] = i_data[BIT_VALID] & ~kill_in;

        slot_d = i_en ? load_entry : next_entry;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Outputs are forced quiet during reset, before the first reset edge has cleared the slot.
    always_comb begin
        o_data = next_entry;
        if (i_rst) begin
            o_data[BIT_VALID] = 1'b0;
        end
    end

    assign o_rslot   = i_rst ? '0 : slot_q;
    assign o_request = ~i_rst & slot_q[BIT_VALID] & slot_q[BIT_RDY1] & slot_q[BIT_RDY2] & ~kill_s;

endmodule

// File: tb/tb_issue_slot_entry.sv
// Self-checking bench for issue_slot_entry: directed scenarios plus randomized
// traffic compared against a field-level reference model of the slot.
module tb_issue_slot_entry;

    localparam int W = 25;

    logic          clk;
    logic          rst;
    logic [W-1:0]  data;
    logic [11:0]   wd;
    logic [2:0]    brkill;
    logic          grant;
    logic          en;
    logic          request;
    logic [W-1:0]  rslot;
    logic [W-1:0]  dout;

    int tests;
    int fails;

    typedef struct {
        logic [6:0] op;
        logic [2:0] brm;
        logic [2:0] tag;
        logic [2:0] prd;
        logic [2:0] pr2;
        logic [2:0] pr1;
        logic       valid;
        logic       rdy2;
        logic       rdy1;
    } ent_t;

    ent_t m;

    localparam logic [W-1:0] BASE = {7'h14, 3'b101, 3'b010, 3'b001, 3'b011, 3'b001, 3'b000};
    localparam logic [11:0]  WD_IDLE = {3'b110, 3'b110, 3'b110, 3'b110};

    issue_slot_entry #(.WIDTH_REG(3), .WIDTH_TAG(3), .WIDTH_BRM(3)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_WDest4x (wd),
        .i_BrKill  (brkill),
        .i_grant   (grant),
        .i_en      (en),
        .o_request (request),
        .o_rslot   (rslot),
        .o_data    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input ent_t e);
        return {e.op, e.brm, e.tag, e.prd, e.pr2, e.pr1, e.valid, e.rdy2, e.rdy1};
    endfunction

    function automatic ent_t unpack(input logic [W-1:0] d);
        ent_t e;
        {e.op, e.brm, e.tag, e.prd, e.pr2, e.pr1, e.valid, e.rdy2, e.rdy1} = d;
        return e;
    endfunction

    function automatic logic snooped(input logic [2:0] pr);
        logic [2:0] ports [4];
        ports[0] = wd[2:0];
        ports[1] = wd[5:3];
        ports[2] = wd[8:6];
        ports[3] = wd[11:9];
        foreach (ports[k]) if (ports[k] == pr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic killed(input ent_t e);
        return (e.brm & brkill) != 3'b000;
    endfunction

    function automatic ent_t hold_next(input ent_t e);
        ent_t n;
        n = e;
        n.rdy1  = e.rdy1 || snooped(e.pr1);
        n.rdy2  = e.rdy2 || snooped(e.pr2);
        n.valid = e.valid && !killed(e) && !grant;
        return n;
    endfunction

    function automatic logic exp_request();
        return !rst && m.valid && m.rdy1 && m.rdy2 && !killed(m);
    endfunction

    function automatic logic [W-1:0] exp_rslot();
        return rst ? '0 : pack(m);
    endfunction

    function automatic logic [W-1:0] exp_dout();
        ent_t n;
        n = hold_next(m);
        if (rst) n.valid = 1'b0;
        return pack(n);
    endfunction

    // Advance the reference model by the current inputs, then cross the clock edge.
    task automatic tick();
        ent_t n;
        if (rst) begin
            n = unpack('0);
        end else if (en) begin
            n       = unpack(data);
            n.rdy1  = n.rdy1 || snooped(n.pr1);
            n.rdy2  = n.rdy2 || snooped(n.pr2);
            n.valid = n.valid && !killed(n);
        end else begin
            n = hold_next(m);
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; en = 1'b0; grant = 1'b0; brkill = 3'b000; wd = WD_IDLE; data = BASE;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #1;
        tests++;
        if (request !== 1'b0) begin fails++; $display("FAIL reset_req_pre got=%b exp=0", request); end
        tests++;
        if (rslot !== '0) begin fails++; $display("FAIL reset_rslot_pre got=%h exp=0", rslot); end
        tests++;
        if (dout[2] !== 1'b0) begin fails++; $display("FAIL reset_dvalid_pre got=%b exp=0", dout[2]); end
        tick();
        tick();
        tests++;
        if (rslot !== '0) begin fails++; $display("FAIL reset_rslot got=%h exp=0", rslot); end
        rst = 1'b0;
        en = 1'b1; data = BASE | 25'b100;
        tick();
        en = 1'b0;
        #1;
        tests++;
        if (rslot !== (BASE | 25'b100)) begin fails++; $display("FAIL load_rslot got=%h exp=%h", rslot, BASE | 25'b100); end
        tests++;
        if (request !== 1'b0) begin fails++; $display("FAIL load_req got=%b exp=0", request); end
    endtask

    task automatic test_wakeup();
        wd = {3'b110, 3'b110, 3'b110, 3'b001};
        tick();
        wd = WD_IDLE;
        #1;
        tests++;
        if (rslot[2:0] !== 3'b101) begin fails++; $display("FAIL wake1_flags got=%b exp=101", rslot[2:0]); end
        tests++;
        if (request !== 1'b0) begin fails++; $display("FAIL wake1_req got=%b exp=0", request); end
        wd = {3'b110, 3'b110, 3'b011, 3'b110};
        #1;
        tests++;
        if (request !== 1'b0) begin fails++; $display("FAIL wake2_sameclk_req got=%b exp=0", request); end
        tests++;
        if (dout[2:0] !== 3'b111) begin fails++; $display("FAIL wake2_dout_flags got=%b exp=111", dout[2:0]); end
        tick();
        wd = WD_IDLE;
        #1;
        tests++;
        if (rslot[2:0] !== 3'b111) begin fails++; $display("FAIL wake2_flags got=%b exp=111", rslot[2:0]); end
        tests++;
        if (request !== 1'b1) begin fails++; $display("FAIL wake2_req got=%b exp=1", request); end
    endtask

    task automatic test_grant();
        grant = 1'b1;
        tick();
        grant = 1'b0;
        #1;
        tests++;
        if (rslot[2:0] !== 3'b011) begin fails++; $display("FAIL grant_flags got=%b exp=011", rslot[2:0]); end
        tests++;
        if (request !== 1'b0) begin fails++; $display("FAIL grant_req got=%b exp=0", request); end
        grant = 1'b1;
        tick();
        tick();
        grant = 1'b0;
        #1;
        tests++;
        if (rslot !== (BASE | 25'b011)) begin fails++; $display("FAIL regrant_rslot got=%h exp=%h", rslot, BASE | 25'b011); end
    endtask

    task automatic test_kill_no_overlap();
        en = 1'b1; data = BASE | 25'b111; brkill = 3'b010;
        tick();
        en = 1'b0;
        #1;
        tests++;
        if (request !== 1'b1) begin fails++; $display("FAIL nokill_load_req got=%b exp=1", request); end
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (request !== 1'b1) begin fails++; $display("FAIL nokill_idle_req got=%b exp=1", request); end
    endtask

    task automatic test_kill();
        brkill = 3'b101;
        #1;
        tests++;
        if (request !== 1'b0) begin fails++; $display("FAIL kill_comb_req got=%b exp=0", request); end
        tests++;
        if (dout[2] !== 1'b0) begin fails++; $display("FAIL kill_dout_valid got=%b exp=0", dout[2]); end
        tick();
        brkill = 3'b000;
        #1;
        tests++;
        if (rslot[2] !== 1'b0) begin fails++; $display("FAIL kill_valid got=%b exp=0", rslot[2]); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; data = BASE | 25'b111;
        tick();
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (rslot !== '0) begin fails++; $display("FAIL midrst_rslot got=%h exp=0", rslot); end
        tests++;
        if (request !== 1'b0) begin fails++; $display("FAIL midrst_req got=%b exp=0", request); end
        en = 1'b1; data = BASE | 25'b100; wd = {3'b110, 3'b011, 3'b110, 3'b110};
        tick();
        en = 1'b0; wd = WD_IDLE;
        #1;
        tests++;
        if (rslot[2:0] !== 3'b110) begin fails++; $display("FAIL load_wake_flags got=%b exp=110", rslot[2:0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 24) == 0);
            en     = ($urandom_range(0, 3) == 0);
            grant  = ($urandom_range(0, 2) == 0);
            brkill = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            wd     = 12'($urandom);
            data   = 25'($urandom);
            #1;
            tests++;
            if (request !== exp_request()) begin fails++; $display("FAIL rand_req cyc=%0d got=%b exp=%b", i, request, exp_request()); end
            tests++;
            if (rslot !== exp_rslot()) begin fails++; $display("FAIL rand_rslot cyc=%0d got=%h exp=%h", i, rslot, exp_rslot()); end
            tests++;
            if (dout !== exp_dout()) begin fails++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", i, dout, exp_dout()); end
            tick();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m = unpack('0);
        set_idle();
        #2;
        test_reset();
        test_wakeup();
        test_grant();
        test_kill_no_overlap();
        test_kill();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
